// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state encoding and time field widths for the alarm sequencer
package alarm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_t;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int DAY_W  = 3;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - registered rising-edge detector for a button level
module btn_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic in,
    output logic pulse
);

    logic prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= in;
            pulse <= in & ~prev;
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - decides when the alarm rings and sequences ring/snooze/stop/mute
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_MAX_MIN = 10,
    parameter int MAX_SNOOZES  = 3,
    parameter int BEEP_DIV     = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              min_tick,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [DAY_W-1:0]  cur_day,
    input  logic [HOUR_W-1:0] alm_hour,
    input  logic [MIN_W-1:0]  alm_min,
    input  logic [6:0]        alm_days,
    input  logic              alarm_en,
    input  logic              set_mode,
    input  logic              Snooze,
    input  logic              Stop,
    input  logic              Mute,
    output logic              Sound,
    output logic              ringing,
    output logic              snoozing,
    output logic [2:0]        snooze_cnt
);

    localparam int             BW          = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
    localparam logic [BW-1:0]  BEEP_LAST   = BW'(BEEP_DIV - 1);
    localparam logic [3:0]     SNOOZE_INIT = 4'(SNOOZE_MIN);
    localparam logic [3:0]     RING_LAST   = 4'(RING_MAX_MIN);
    localparam logic [2:0]     SNOOZE_LIM  = 3'(MAX_SNOOZES);

    state_t        state, state_n;
    logic [3:0]    ring_min, ring_min_n, ring_inc;
    logic [3:0]    snooze_timer, snooze_timer_n;
    logic [2:0]    snooze_cnt_n;
    logic          mute, mute_n;
    logic [BW-1:0] beep, beep_n;
    logic          sound_n;
    logic          restart;
    logic          match;
    logic          snooze_p, stop_p, mute_p;

    btn_edge u_snooze (.Clk(Clk), .Reset(Reset), .in(Snooze), .pulse(snooze_p));
    btn_edge u_stop   (.Clk(Clk), .Reset(Reset), .in(Stop),   .pulse(stop_p));
    btn_edge u_mute   (.Clk(Clk), .Reset(Reset), .in(Mute),   .pulse(mute_p));

    assign match = min_tick & alarm_en & ~set_mode & (cur_hour == alm_hour) &
                   (cur_min == alm_min) & alm_days[cur_day];

    always_comb begin
        state_n        = state;
        ring_min_n     = ring_min;
        snooze_timer_n = snooze_timer;
        snooze_cnt_n   = snooze_cnt;
        mute_n         = mute;
        restart        = 1'b0;
        ring_inc       = ring_min + 4'd1;
        sound_n        = Sound;
        beep_n         = beep;

        if (!alarm_en || set_mode) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (match) begin
                        state_n      = ST_RING;
                        snooze_cnt_n = 3'd0;
                        restart      = 1'b1;
                    end
                end
                ST_RING: begin
                    if (stop_p) begin
                        state_n = ST_IDLE;
                    end else if (snooze_p && (snooze_cnt < SNOOZE_LIM)) begin
                        state_n        = ST_SNOOZE;
                        snooze_timer_n = SNOOZE_INIT;
                        snooze_cnt_n   = snooze_cnt + 3'd1;
                    end else if (mute_p) begin
                        mute_n = 1'b1;
                    end else if (min_tick) begin
                        if (ring_inc == RING_LAST)
                            state_n = ST_IDLE;
                        else
                            ring_min_n = ring_inc;
                    end
                end
                ST_SNOOZE: begin
                    if (stop_p) begin
                        state_n = ST_IDLE;
                    end else if (min_tick) begin
                        // Treat an already-zero timer as expired so it can never wrap.
                        if (snooze_timer > 4'd1) begin
                            snooze_timer_n = snooze_timer - 4'd1;
                        end else begin
                            snooze_timer_n = 4'd0;
                            state_n        = ST_RING;
                            restart        = 1'b1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        if (restart) begin
            ring_min_n = 4'd0;
            mute_n     = 1'b0;
        end

        if (state_n == ST_IDLE) begin
            ring_min_n     = 4'd0;
            snooze_timer_n = 4'd0;
            snooze_cnt_n   = 3'd0;
            mute_n         = 1'b0;
        end

        // Beep pattern restarts high on every (re)entry to RING.
        if (state_n != ST_RING || mute_n) begin
            sound_n = 1'b0;
            beep_n  = '0;
        end else if (restart) begin
            sound_n = 1'b1;
            beep_n  = '0;
        end else if (beep == BEEP_LAST) begin
            sound_n = ~Sound;
            beep_n  = '0;
        end else begin
            beep_n = beep + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= ST_IDLE;
            ring_min     <= 4'd0;
            snooze_timer <= 4'd0;
            snooze_cnt   <= 3'd0;
            mute         <= 1'b0;
            beep         <= '0;
            Sound        <= 1'b0;
            ringing      <= 1'b0;
            snoozing     <= 1'b0;
        end else begin
            state        <= state_n;
            ring_min     <= ring_min_n;
            snooze_timer <= snooze_timer_n;
            snooze_cnt   <= snooze_cnt_n;
            mute         <= mute_n;
            beep         <= beep_n;
            Sound        <= sound_n;
            ringing      <= (state_n == ST_RING);
            snoozing     <= (state_n == ST_SNOOZE);
        end
    end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Control block that decides when the alarm clock rings and sequences the ring / snooze / stop / mute behaviour. It sits beside the clock datapath. It watches the current time on a one-cycle minute-rollover pulse, compares it against the stored alarm time and day mask, and drives Sound plus status flags back to the display logic. It owns all alarm session state; the datapath only supplies time values and button levels.

Parameters:
SNOOZE_MIN, 5, minutes per snooze interval (1..15)
RING_MAX_MIN, 10, minutes of unattended ringing before auto-stop (1..15)
MAX_SNOOZES, 3, snoozes allowed per alarm session (1..7)
BEEP_DIV, 4, Clk cycles per Sound half-period (>=1)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
min_tick  in  1  one-cycle pulse; cur_* already hold the new minute on that cycle
cur_hour  in  5  current hour 0..23
cur_min  in  6  current minute 0..59
cur_day  in  3  current day 0..6
alm_hour  in  5  alarm hour 0..23
alm_min  in  6  alarm minute 0..59
alm_days  in  7  alarm day mask, bit n = day n
alarm_en  in  1  alarm armed (level)
set_mode  in  1  SetTime or SetAlarm active (level)
Snooze  in  1  button level
Stop  in  1  button level
Mute  in  1  button level
Sound  out  1  buzzer drive
ringing  out  1  state == RING
snoozing  out  1  state == SNOOZE
snooze_cnt  out  3  snoozes used in the current session

Behaviour:
- Reset (async): state IDLE; Sound, ringing, snoozing, snooze_cnt, mute flag, ring_min, snooze_timer, beep counter all 0.
- Buttons: registered rising-edge detect; an action takes effect on the first Clk edge after the edge is sampled (2-cycle latency from input rise to state change). A held button acts once.
- match = min_tick & alarm_en & ~set_mode & (cur_hour==alm_hour) & (cur_min==alm_min) & alm_days[cur_day]. Evaluated only on min_tick, so at most one trigger per minute.
- States: IDLE, RING, SNOOZE (encoding in package).
- IDLE: on match go to RING; clear ring_min, mute, snooze_cnt.
- RING, priority highest first:
  1. Stop goes to IDLE.
  2. Snooze with snooze_cnt < MAX_SNOOZES goes to SNOOZE; snooze_timer = SNOOZE_MIN; snooze_cnt += 1. When snooze_cnt == MAX_SNOOZES, Snooze is ignored.
  3. Mute sets mute (sticky until RING is left).
  4. min_tick increments ring_min. When the result equals RING_MAX_MIN, go to IDLE.
- SNOOZE, priority: Stop goes to IDLE; else on min_tick decrement snooze_timer. When the timer goes 1 to 0, go to RING with ring_min = 0 and mute = 0. Snooze and Mute are ignored in SNOOZE.
- Any state: alarm_en low or set_mode high forces IDLE on the next edge. This outranks everything else.
- A match arriving while in RING or SNOOZE is ignored.
- Entering IDLE clears snooze_cnt, mute, ring_min and snooze_timer.
- Sound: 0 unless state == RING and mute == 0.
  - On entry to RING, or when leaving SNOOZE, Sound = 1 and the beep counter = 0.
  - Sound toggles every BEEP_DIV cycles thereafter.
  - Sound is registered.
- ringing and snoozing are registered decodes of state and change on the same edge as state.
- Counter widths: ring_min, snooze_timer 4 bits; beep counter sized by $clog2(BEEP_DIV). No counter wraps; every limit is compared explicitly.

Decomposition:
- Package alarm_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RING=2'd1, ST_SNOOZE=2'd2;
  - field widths HOUR_W=5, MIN_W=6, DAY_W=3.
- One sub-module, btn_edge (Clk, Reset, in, pulse): registered rising-edge detector, instantiated three times for Snooze, Stop and Mute.

Test Plan:
- Match: alm 07:30, alm_days=7'b0000010, cur_day=1, alarm_en=1; min_tick with cur 07:30 -> ringing=1 next edge, Sound=1, toggles every 4 cycles. Same setup with cur_day=2 -> stays IDLE.
- Snooze cycle: ringing, pulse Snooze -> snoozing=1, snooze_cnt=1, Sound=0. After 5 min_ticks -> ringing=1, Sound=1. Repeat to snooze_cnt=3; a 4th Snooze is ignored, ringing stays 1.
- Timeout: ringing, no buttons, 10 min_ticks -> IDLE on the 10th; Sound=0, snooze_cnt=0.
- Mute/Stop: ringing, Mute -> Sound=0 while ringing=1. Stop -> IDLE. Next match -> Sound=1 (mute cleared).
- Priority: Stop and Snooze rise on the same cycle in RING -> IDLE. Snooze coinciding with the 10th ring min_tick -> SNOOZE. set_mode=1 during SNOOZE -> IDLE next edge.
- Reset mid-RING: assert Reset asynchronously -> Sound, ringing and snooze_cnt go to 0 immediately without a clock; after release, no ring until the next match.
